// File: rtl/pipe_ctrl_if.sv
// Handshake/status bundle between the pipeline flow controller and the datapath.
interface pipe_ctrl_if;
    logic [31:0] d_active_reg;
    logic [4:0]  d_rd;
    logic        d_wb_en;
    logic        d_jmp;
    logic        mw_taken;
    logic [31:0] mw_target;
    logic        mw_fault;
    logic [31:0] pc;
    logic        fetch_en;
    logic        fd_valid;
    logic        dr_valid;
    logic        ra_valid;
    logic        am_valid;
    logic        mw_valid;
    logic        stalled;

    modport master (
        input  d_active_reg, d_rd, d_wb_en, d_jmp, mw_taken, mw_target, mw_fault,
        output pc, fetch_en, fd_valid, dr_valid, ra_valid, am_valid, mw_valid, stalled
    );

    modport slave (
        output d_active_reg, d_rd, d_wb_en, d_jmp, mw_taken, mw_target, mw_fault,
        input  pc, fetch_en, fd_valid, dr_valid, ra_valid, am_valid, mw_valid, stalled
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Flow controller for the F/D/R/A/M/W pipeline: owns fetch PC, buffer valids, RAW scoreboard, jumps, fault recovery.
// Optional PIPE_CTRL_STATS_EN adds stall/jump/taken event counters.
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter logic [31:0] FAULT_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PIPE_CTRL_STATS_EN
    output logic [31:0] stat_stall,
    output logic [31:0] stat_jump,
    output logic [31:0] stat_taken,
`endif
    pipe_ctrl_if.master bus
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_JMP_WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wb;
        logic       jmp;
    } sb_t;

    state_t      state;
    logic [31:0] pc_q;
    logic        fd_q;
    sb_t         dr_q;
    sb_t         ra_q;
    sb_t         am_q;
    // MW never contributes to the pending mask, so only its valid and jump marker are kept.
    logic        mw_v_q;
    logic        mw_jmp_q;

    logic [31:0] pending;
    logic        hazard;
    logic        fault;
    logic        in_run;
    logic        jmp_issue;
    logic        jmp_resolve;
    logic        fetch;
    sb_t         fd_entry;

    always_comb begin
        pending = '0;
        if (dr_q.v && dr_q.wb && (dr_q.rd != 5'd0)) pending[dr_q.rd] = 1'b1;
        if (ra_q.v && ra_q.wb && (ra_q.rd != 5'd0)) pending[ra_q.rd] = 1'b1;
        if (am_q.v && am_q.wb && (am_q.rd != 5'd0)) pending[am_q.rd] = 1'b1;
        pending[0] = 1'b0;
    end

    always_comb begin
        fd_entry    = '{v: 1'b1, rd: bus.d_rd, wb: bus.d_wb_en, jmp: bus.d_jmp};
        fault       = mw_v_q && bus.mw_fault;
        hazard      = fd_q && ((bus.d_active_reg & pending & ~32'h1) != 32'h0);
        in_run      = (state == ST_RUN);
        jmp_issue   = !fault && in_run && !hazard && fd_q && bus.d_jmp;
        fetch       = !fault && in_run && !hazard && !(fd_q && bus.d_jmp);
        jmp_resolve = !fault && (state == ST_JMP_WAIT) && mw_v_q && mw_jmp_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            pc_q     <= RESET_PC;
            fd_q     <= 1'b0;
            dr_q     <= '0;
            ra_q     <= '0;
            am_q     <= '0;
            mw_v_q   <= 1'b0;
            mw_jmp_q <= 1'b0;
        end else if (fault) begin
            state    <= ST_RUN;
            pc_q     <= FAULT_PC;
            fd_q     <= 1'b0;
            dr_q     <= '0;
            ra_q     <= '0;
            am_q     <= '0;
            mw_v_q   <= 1'b0;
            mw_jmp_q <= 1'b0;
        end else begin
            ra_q     <= dr_q;
            am_q     <= ra_q;
            mw_v_q   <= am_q.v;
            mw_jmp_q <= am_q.jmp;
            case (state)
                ST_RUN: begin
                    if (hazard) begin
                        dr_q <= '0;
                    end else if (fd_q && bus.d_jmp) begin
                        dr_q  <= fd_entry;
                        fd_q  <= 1'b0;
                        state <= ST_JMP_WAIT;
                    end else begin
                        pc_q <= pc_q + 32'd4;
                        fd_q <= 1'b1;
                        dr_q <= fd_q ? fd_entry : '0;
                    end
                end
                ST_JMP_WAIT: begin
                    dr_q <= '0;
                    fd_q <= 1'b0;
                    // pc already points past the jump, so not-taken simply resumes from it.
                    if (mw_v_q && mw_jmp_q) begin
                        if (bus.mw_taken) pc_q <= bus.mw_target;
                        state <= ST_RUN;
                    end
                end
                default: begin
                    state <= ST_RUN;
                    dr_q  <= '0;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_stall <= '0;
            stat_jump  <= '0;
            stat_taken <= '0;
        end else begin
            if (!fault && in_run && hazard) stat_stall <= stat_stall + 32'd1;
            if (jmp_issue)                  stat_jump  <= stat_jump + 32'd1;
            if (jmp_resolve && bus.mw_taken) stat_taken <= stat_taken + 32'd1;
        end
    end
`endif

    assign bus.pc       = pc_q;
    assign bus.fetch_en = fetch;
    assign bus.fd_valid = fd_q;
    assign bus.dr_valid = dr_q.v;
    assign bus.ra_valid = ra_q.v;
    assign bus.am_valid = am_q.v;
    assign bus.mw_valid = mw_v_q;
    assign bus.stalled  = hazard;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle vector table plus hand sequences for fault-in-stall and mid-stream reset.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipe_ctrl_if bus();

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stat_stall;
    logic [31:0] stat_jump;
    logic [31:0] stat_taken;
`endif

    pipe_ctrl #(.RESET_PC(32'h0), .FAULT_PC(32'h200)) dut (
        .clk(clk),
        .rst(rst),
`ifdef PIPE_CTRL_STATS_EN
        .stat_stall(stat_stall),
        .stat_jump(stat_jump),
        .stat_taken(stat_taken),
`endif
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] act;
        logic [4:0]  rd;
        logic        wb;
        logic        jmp;
        logic        tk;
        logic [31:0] tgt;
        logic        flt;
        logic [31:0] pc;
        logic [6:0]  flg;   // {fetch_en, fd, dr, ra, am, mw, stalled}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [31:0] a, input logic [4:0] r, input logic w, input logic j,
                                input logic t, input logic [31:0] g, input logic f,
                                input logic [31:0] p, input logic [6:0] fl);
        vec_t v;
        v.act = a; v.rd = r; v.wb = w; v.jmp = j; v.tk = t; v.tgt = g; v.flt = f;
        v.pc = p; v.flg = fl;
        return v;
    endfunction

    function automatic logic [6:0] flags();
        return {bus.fetch_en, bus.fd_valid, bus.dr_valid, bus.ra_valid,
                bus.am_valid, bus.mw_valid, bus.stalled};
    endfunction

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [4:0] r, input logic w, input logic j,
                         input logic t, input logic [31:0] g, input logic f);
        bus.d_active_reg = a;
        bus.d_rd         = r;
        bus.d_wb_en      = w;
        bus.d_jmp        = j;
        bus.mw_taken     = t;
        bus.mw_target    = g;
        bus.mw_fault     = f;
    endtask

    task automatic state_chk(input string name, input logic [31:0] p, input logic [6:0] fl);
        check(name, {57'b0, flags(), bus.pc}, {57'b0, fl, p});
    endtask

`ifdef PIPE_CTRL_STATS_EN
    task automatic stats_chk(input string name, input logic [31:0] s, input logic [31:0] j, input logic [31:0] t);
        check(name, {stat_stall, stat_jump, stat_taken}, {s, j, t});
    endtask
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // args: act, rd, wb, jmp, taken, target, fault, exp pc, exp flags
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h00, 7'b1000000));
        tbl.push_back(mk(32'h0,    5'd1, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h04, 7'b1100000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h08, 7'b1110000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h0C, 7'b1111000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h10, 7'b1111100));
        tbl.push_back(mk(32'h0,    5'd5, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h14, 7'b1111110));
        tbl.push_back(mk(32'h20,   5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h18, 7'b0111111));
        tbl.push_back(mk(32'h20,   5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h18, 7'b0101111));
        tbl.push_back(mk(32'h20,   5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h18, 7'b0100111));
        tbl.push_back(mk(32'h20,   5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h18, 7'b1100010));
        tbl.push_back(mk(32'h0,    5'd0, 1'b1, 1'b0, 1'b0, 32'h0,  1'b0, 32'h1C, 7'b1110000));
        tbl.push_back(mk(32'h1,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h20, 7'b1111000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h24, 7'b0111100));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h24, 7'b0011110));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h24, 7'b0001110));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h24, 7'b0000110));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 32'h24, 7'b0000010));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h40, 7'b1000000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h44, 7'b0100000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 7'b0010000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 7'b0001000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 7'b0000100));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h40, 1'b0, 32'h44, 7'b0000010));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h44, 7'b1000000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b1, 1'b0, 32'h0,  1'b0, 32'h48, 7'b0100000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h48, 7'b0010000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h48, 7'b0001000));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h48, 7'b0000100));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h48, 7'b0000010));
        tbl.push_back(mk(32'h0,    5'd0, 1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 32'h200, 7'b1000000));

        rst = 1'b1;
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].act, tbl[i].rd, tbl[i].wb, tbl[i].jmp, tbl[i].tk, tbl[i].tgt, tbl[i].flt);
            @(negedge clk);
            state_chk($sformatf("vec%0d", i), tbl[i].pc, tbl[i].flg);
            step();
        end
`ifdef PIPE_CTRL_STATS_EN
        stats_chk("stats_after_table", 32'd3, 32'd3, 32'd1);
`endif

        // Fault arriving while a RAW stall is active.
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        state_chk("fs_h0", 32'h204, 7'b1100000);
        step();
        step();
        drive(32'h0, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step();
        drive(32'h80, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        state_chk("fs_stall", 32'h210, 7'b0111101);
        step();
        drive(32'h80, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        state_chk("fs_stall_mw", 32'h210, 7'b0101111);
        step();
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        state_chk("fs_recover", 32'h200, 7'b1000000);
`ifdef PIPE_CTRL_STATS_EN
        stats_chk("stats_after_fault", 32'd4, 32'd3, 32'd1);
`endif
        step();

        // Reset pulse while waiting on a jump.
        drive(32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        state_chk("rst_pre_jmp", 32'h204, 7'b0100000);
        step();
        drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        state_chk("rst_mid", 32'h0, 7'b1000000);
`ifdef PIPE_CTRL_STATS_EN
        stats_chk("stats_after_rst", 32'd0, 32'd0, 32'd0);
`endif
        step();
        @(negedge clk);
        state_chk("rst_resume", 32'h4, 7'b1100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
